// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory read port between a cache and a store buffer.
// Optional WAIT timeout (rdata=0, err_o pulse) is enabled by defining ARB_TIMEOUT_EN.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cache_req_i,
  input  logic [ADDR_W-1:0] cache_addr_i,
  output logic              cache_gnt_o,
  output logic              cache_rvalid_o,
  output logic [DATA_W-1:0] cache_rdata_o,
  input  logic              strBuf_req_i,
  input  logic [ADDR_W-1:0] strBuf_addr_i,
  output logic              strBuf_gnt_o,
  output logic              strBuf_rvalid_o,
  output logic [DATA_W-1:0] strBuf_rdata_o,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_wait_i,
  input  logic              mem_ready_i,
  input  logic [DATA_W-1:0] mem_data_i,
  output logic              err_o,
  output logic [1:0]        outState
);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StWait  = 2'd2,
    StResp  = 2'd3
  } state_e;

  state_e            state_q;
  logic              win_strbuf_q;   // owner of the in-flight transaction
  logic              prio_strbuf_q;  // store buffer wins the next tie
  logic              mem_req_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic              cache_gnt_q;
  logic              strbuf_gnt_q;
  logic              cache_rvalid_q;
  logic              strbuf_rvalid_q;
  logic [DATA_W-1:0] cache_rdata_q;
  logic [DATA_W-1:0] strbuf_rdata_q;
  logic              pick_strbuf;

  // mem_wait_i is status only and has no effect on sequencing.
  logic unused_cfg;
  assign unused_cfg = mem_wait_i | (TIMEOUT_CYCLES == 0);

  assign pick_strbuf = strBuf_req_i & (~cache_req_i | prio_strbuf_q);

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CntW-1:0] wait_cnt_q;
  logic            err_q;
  logic            timeout;

  assign timeout = (wait_cnt_q == CntW'(TIMEOUT_CYCLES - 1));
  assign err_o   = err_q;
`else
  assign err_o   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= StIdle;
      win_strbuf_q    <= 1'b0;
      prio_strbuf_q   <= 1'b0;
      mem_req_q       <= 1'b0;
      mem_addr_q      <= '0;
      cache_gnt_q     <= 1'b0;
      strbuf_gnt_q    <= 1'b0;
      cache_rvalid_q  <= 1'b0;
      strbuf_rvalid_q <= 1'b0;
      cache_rdata_q   <= '0;
      strbuf_rdata_q  <= '0;
`ifdef ARB_TIMEOUT_EN
      wait_cnt_q      <= '0;
      err_q           <= 1'b0;
`endif
    end else begin
      mem_req_q       <= 1'b0;
      cache_gnt_q     <= 1'b0;
      strbuf_gnt_q    <= 1'b0;
      cache_rvalid_q  <= 1'b0;
      strbuf_rvalid_q <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      err_q           <= 1'b0;
`endif
      unique case (state_q)
        StIdle: begin
          if (cache_req_i | strBuf_req_i) begin
            win_strbuf_q <= pick_strbuf;
            mem_addr_q   <= pick_strbuf ? strBuf_addr_i : cache_addr_i;
            mem_req_q    <= 1'b1;
            cache_gnt_q  <= ~pick_strbuf;
            strbuf_gnt_q <= pick_strbuf;
            state_q      <= StIssue;
          end
        end
        StIssue: begin
          state_q <= StWait;
`ifdef ARB_TIMEOUT_EN
          wait_cnt_q <= '0;
`endif
        end
        StWait: begin
          if (mem_ready_i) begin
            if (win_strbuf_q) strbuf_rdata_q <= mem_data_i;
            else              cache_rdata_q  <= mem_data_i;
            cache_rvalid_q  <= ~win_strbuf_q;
            strbuf_rvalid_q <= win_strbuf_q;
            state_q         <= StResp;
          end
`ifdef ARB_TIMEOUT_EN
          else if (timeout) begin
            if (win_strbuf_q) strbuf_rdata_q <= '0;
            else              cache_rdata_q  <= '0;
            cache_rvalid_q  <= ~win_strbuf_q;
            strbuf_rvalid_q <= win_strbuf_q;
            err_q           <= 1'b1;
            state_q         <= StResp;
          end else begin
            wait_cnt_q <= wait_cnt_q + CntW'(1);
          end
`endif
        end
        StResp: begin
          prio_strbuf_q <= ~win_strbuf_q;
          state_q       <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign cache_gnt_o     = cache_gnt_q;
  assign strBuf_gnt_o    = strbuf_gnt_q;
  assign cache_rvalid_o  = cache_rvalid_q;
  assign strBuf_rvalid_o = strbuf_rvalid_q;
  assign cache_rdata_o   = cache_rdata_q;
  assign strBuf_rdata_o  = strbuf_rdata_q;
  assign mem_req_o       = mem_req_q;
  assign mem_addr_o      = mem_addr_q;
  assign outState        = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus random traffic, checked each cycle
// against a transaction-timing model (sample edge, completion edge, last-served requester).
module tb_mem_port_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned TO = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          cache_req_i, strBuf_req_i;
  logic [AW-1:0] cache_addr_i, strBuf_addr_i;
  logic          cache_gnt_o, cache_rvalid_o, strBuf_gnt_o, strBuf_rvalid_o;
  logic [DW-1:0] cache_rdata_o, strBuf_rdata_o;
  logic          mem_req_o;
  logic [AW-1:0] mem_addr_o;
  logic          mem_wait_i, mem_ready_i;
  logic [DW-1:0] mem_data_i;
  logic          err_o;
  logic [1:0]    outState;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W        (AW),
    .DATA_W        (DW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .cache_req_i    (cache_req_i),
    .cache_addr_i   (cache_addr_i),
    .cache_gnt_o    (cache_gnt_o),
    .cache_rvalid_o (cache_rvalid_o),
    .cache_rdata_o  (cache_rdata_o),
    .strBuf_req_i   (strBuf_req_i),
    .strBuf_addr_i  (strBuf_addr_i),
    .strBuf_gnt_o   (strBuf_gnt_o),
    .strBuf_rvalid_o(strBuf_rvalid_o),
    .strBuf_rdata_o (strBuf_rdata_o),
    .mem_req_o      (mem_req_o),
    .mem_addr_o     (mem_addr_o),
    .mem_wait_i     (mem_wait_i),
    .mem_ready_i    (mem_ready_i),
    .mem_data_i     (mem_data_i),
    .err_o          (err_o),
    .outState       (outState)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int e        = 0;

  // Reference model: a transaction is described by the edge it was sampled on (m_ts) and the
  // edge it completed on (m_td, 0 while outstanding). m_last_s = store buffer served last.
  bit            m_busy;
  bit            m_who;
  bit            m_last_s;
  bit            m_err;
  int            m_ts, m_td;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_rd [2];

  bit            served_q[$];
  int            lat_q[$];
  int            gnt_e_s;
  int            cycles;
  bit            pc, ps;
  logic [AW-1:0] ac, as_;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", tag, act, exp, e);
    end
  endtask

  task automatic step(input bit rst, input bit creq, input logic [AW-1:0] caddr,
                      input bit sreq, input logic [AW-1:0] saddr,
                      input bit rdy, input logic [DW-1:0] data);
    logic [1:0] exp_st;
    bit         exp_issue, exp_done;
    reset         = rst;
    cache_req_i   = creq;
    cache_addr_i  = caddr;
    strBuf_req_i  = sreq;
    strBuf_addr_i = saddr;
    mem_ready_i   = rdy;
    mem_data_i    = data;
    mem_wait_i    = 1'($urandom_range(0, 1));
    @(posedge clk);
    e++;
    m_err = 1'b0;
    if (rst) begin
      m_busy   = 1'b0;
      m_last_s = 1'b1;
      m_addr   = '0;
      m_rd[0]  = '0;
      m_rd[1]  = '0;
    end else if (m_busy) begin
      if (m_td != 0) begin
        m_busy = 1'b0;
      end else if (e >= m_ts + 2) begin
        if (rdy) begin
          m_td        = e;
          m_rd[m_who] = data;
          m_last_s    = m_who;
        end
`ifdef ARB_TIMEOUT_EN
        else if (e - m_ts - 1 == int'(TO)) begin
          m_td        = e;
          m_rd[m_who] = '0;
          m_err       = 1'b1;
          m_last_s    = m_who;
        end
`endif
      end
    end else if (creq || sreq) begin
      m_who  = (creq && sreq) ? !m_last_s : sreq;
      m_addr = m_who ? saddr : caddr;
      m_busy = 1'b1;
      m_ts   = e;
      m_td   = 0;
    end
    #1;
    exp_issue = m_busy && (e == m_ts);
    exp_done  = m_busy && (m_td == e);
    exp_st    = !m_busy ? 2'd0 : exp_issue ? 2'd1 : exp_done ? 2'd3 : 2'd2;
    check_eq("cache_gnt", cache_gnt_o, exp_issue && !m_who);
    check_eq("strbuf_gnt", strBuf_gnt_o, exp_issue && m_who);
    check_eq("mem_req", mem_req_o, exp_issue);
    if (exp_issue || rst) check_eq("mem_addr", mem_addr_o, m_addr);
    check_eq("cache_rvalid", cache_rvalid_o, exp_done && !m_who);
    check_eq("strbuf_rvalid", strBuf_rvalid_o, exp_done && m_who);
    check_eq("cache_rdata", cache_rdata_o, m_rd[0]);
    check_eq("strbuf_rdata", strBuf_rdata_o, m_rd[1]);
    check_eq("err", err_o, m_err);
    check_eq("state", outState, exp_st);
    if (cache_gnt_o) served_q.push_back(1'b0);
    if (strBuf_gnt_o) begin
      served_q.push_back(1'b1);
      gnt_e_s = e;
    end
    if (strBuf_rvalid_o) lat_q.push_back(e - gnt_e_s + 1);
  endtask

  initial begin
    reset = 1'b1;
    cache_req_i = 1'b0; strBuf_req_i = 1'b0; cache_addr_i = '0; strBuf_addr_i = '0;
    mem_ready_i = 1'b0; mem_wait_i = 1'b0; mem_data_i = '0;
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);

    // Single cache read; ready in IDLE/ISSUE ignored, data arrives after 3 idle WAIT cycles.
    step(0, 1, 'h100, 0, 0, 1, 'hDEADBEEF);
    step(0, 0, 'h100, 0, 0, 1, 'hDEADBEEF);
    repeat (3) step(0, 0, 0, 0, 0, 0, 'h12345678);
    step(0, 0, 0, 0, 0, 1, 'hA5A5A5A5);
    step(0, 0, 0, 0, 0, 1, 'h0BADF00D);
    step(0, 0, 0, 0, 0, 1, 'h0BADF00D);
    check_eq("single_rdata", cache_rdata_o, 'hA5A5A5A5);
    check_eq("single_sb_idle", strBuf_rdata_o, 0);

    // Both requesters held after reset: cache first, then alternate.
    step(1, 0, 0, 0, 0, 0, 0);
    served_q.delete();
    repeat (16) step(0, 1, 'h10, 1, 'h20, 1, $urandom);
    check_eq("rr_count", served_q.size(), 4);
    for (int i = 0; i < served_q.size(); i++) check_eq("rr_order", served_q[i], i % 2);

    // Serve cache (strBuf would be next), then reset mid-WAIT: pointer must favour cache.
    step(0, 1, 'h300, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 'h33);
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 'h400, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 1, 'h44);
    check_eq("rst_wait_state", outState, 0);
    check_eq("rst_wait_rvalid", cache_rvalid_o, 0);
    served_q.delete();
    step(0, 1, 'h10, 1, 'h20, 0, 0);
    check_eq("rst_rr_count", served_q.size(), 1);
    if (served_q.size() > 0) check_eq("rst_rr_cache", served_q[0], 0);
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 'h55);
    step(0, 0, 0, 0, 0, 0, 0);

    // Ten back-to-back store-buffer reads, ready in the first WAIT cycle.
    lat_q.delete();
    cycles = 0;
    while (lat_q.size() < 10 && cycles < 80) begin
      step(0, 0, 0, 1, AW'('h1000 + lat_q.size() * 4), 1, $urandom);
      cycles++;
    end
    check_eq("b2b_count", lat_q.size(), 10);
    foreach (lat_q[i]) check_eq("b2b_latency", lat_q[i], 3);

`ifdef ARB_TIMEOUT_EN
    step(0, 1, 'h500, 0, 0, 0, 0);
    repeat (8) step(0, 0, 0, 0, 0, 0, 'hFFFF);
`endif

    // Random traffic: requesters hold until granted, sporadic ready and reset.
    pc = 1'b0; ps = 1'b0; ac = '0; as_ = '0;
    repeat (400) begin
      if (!pc && $urandom_range(0, 3) == 0) begin pc = 1'b1; ac = $urandom; end
      if (!ps && $urandom_range(0, 3) == 0) begin ps = 1'b1; as_ = $urandom; end
      step($urandom_range(0, 49) == 0, pc, ac, ps, as_, $urandom_range(0, 2) == 0, $urandom);
      if (cache_gnt_o) pc = 1'b0;
      if (strBuf_gnt_o) ps = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
